// File: rtl/mio_bus_arbiter.sv
// Shared memory/IO bus arbiter between the CPU controller and a DMA/loader port.
// Define MIO_CPU_PRIORITY_EN for fixed CPU priority; default is round-robin.
module mio_bus_arbiter #(
  parameter logic [3:0] RAM_WAIT  = 4'd1,
  parameter logic [3:0] IO_WAIT   = 4'd3,
  parameter logic [3:0] IO_REGION = 4'hE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        ram_sel,
  output logic        io_sel,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] io_rdata,
  output logic [1:0]  grant,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        owner;       // 0 = CPU, 1 = DMA
  logic        last_grant;
  logic        is_wr, is_io, illegal;
  logic [31:0] addr_q, wdata_q;
  logic        any_req, pick_dma;
  logic [31:0] sel_addr;
  logic        sel_io;

  assign any_req = cpu_req | dma_req;
`ifdef MIO_CPU_PRIORITY_EN
  assign pick_dma = ~cpu_req;
`else
  // On contention the side that did not win last time gets the bus.
  assign pick_dma = dma_req & (~cpu_req | ~last_grant);
`endif
  assign sel_addr  = pick_dma ? dma_addr : cpu_addr;
  assign sel_io    = sel_addr[31:28] >= IO_REGION;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant     = 2'b00;
    ram_sel   = 1'b0;
    io_sel    = 1'b0;
    bus_we    = 1'b0;
    cpu_ready = 1'b0;
    dma_ready = 1'b0;
    bus_err   = 1'b0;
    case (state)
      ACCESS: begin
        grant   = owner ? 2'b10 : 2'b01;
        ram_sel = ~illegal & ~is_io;
        io_sel  = ~illegal & is_io;
        bus_we  = ~illegal & is_wr;
      end
      DONE: begin
        cpu_ready = ~owner;
        dma_ready = owner;
        bus_err   = illegal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      is_wr      <= 1'b0;
      is_io      <= 1'b0;
      illegal    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      cpu_rdata  <= 32'd0;
      dma_rdata  <= 32'd0;
    end else if (state == IDLE && any_req) begin
      owner   <= pick_dma;
      addr_q  <= sel_addr;
      wdata_q <= pick_dma ? dma_wdata : cpu_wdata;
      is_wr   <= pick_dma ? dma_wr : cpu_wr;
      illegal <= ~pick_dma & (cpu_rd == cpu_wr);
      is_io   <= sel_io;
      cnt     <= sel_io ? IO_WAIT : RAM_WAIT;
    end else if (state == ACCESS) begin
      if (cnt == 4'd0) begin
        last_grant <= owner;
        if (!is_wr && !illegal) begin
          if (owner) dma_rdata <= is_io ? io_rdata : ram_rdata;
          else       cpu_rdata <= is_io ? io_rdata : ram_rdata;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: directed vector table, contention/reset sequences,
// then random traffic against a transaction-schedule reference model.
module tb_mio_bus_arbiter;
  localparam int RAM_W = 1;
  localparam int IO_W  = 3;

  logic        clk = 0, reset = 1;
  logic        cpu_req = 0, cpu_rd = 0, cpu_wr = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic        cpu_ready;
  logic        dma_req = 0, dma_wr = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0, dma_rdata;
  logic        dma_ready;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_we, ram_sel, io_sel, bus_err;
  logic [31:0] ram_rdata = 0, io_rdata = 0;
  logic [1:0]  grant;

  mio_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .ram_sel(ram_sel), .io_sel(io_sel), .ram_rdata(ram_rdata), .io_rdata(io_rdata),
    .grant(grant), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  bit check_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each transaction is a schedule of absolute cycle numbers.
  int          cyc, m_done;
  bit          m_busy, m_last, m_own, m_wr, m_io, m_ill;
  logic [31:0] m_addr, m_wdata, m_crd, m_drd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; m_busy = 0; m_last = 1; m_own = 0; m_crd = 0; m_drd = 0; m_done = 0;
    end else begin
      cyc++;
      if (m_busy) begin
        if (cyc == m_done) begin
          if (!m_wr && !m_ill) begin
            if (m_own) m_drd = m_io ? io_rdata : ram_rdata;
            else       m_crd = m_io ? io_rdata : ram_rdata;
          end
          m_last = m_own;
        end else if (cyc == m_done + 1) m_busy = 0;
      end else if (cpu_req || dma_req) begin
`ifdef MIO_CPU_PRIORITY_EN
        m_own = !cpu_req;
`else
        m_own = (cpu_req && dma_req) ? !m_last : dma_req;
`endif
        m_addr  = m_own ? dma_addr : cpu_addr;
        m_wdata = m_own ? dma_wdata : cpu_wdata;
        m_wr    = m_own ? dma_wr : cpu_wr;
        m_ill   = !m_own && (cpu_rd == cpu_wr);
        m_io    = m_addr[31:28] >= 4'hE;
        m_done  = cyc + (m_io ? IO_W : RAM_W) + 1;
        m_busy  = 1;
      end
    end
  end

  always @(negedge clk) if (check_en && !reset) begin
    bit acc, dn;
    acc = m_busy && cyc < m_done;
    dn  = m_busy && cyc == m_done;
    chk("grant",     grant,     acc ? (m_own ? 2'b10 : 2'b01) : 2'b00);
    chk("ram_sel",   ram_sel,   acc && !m_ill && !m_io);
    chk("io_sel",    io_sel,    acc && !m_ill && m_io);
    chk("bus_we",    bus_we,    acc && !m_ill && m_wr);
    chk("cpu_ready", cpu_ready, dn && !m_own);
    chk("dma_ready", dma_ready, dn && m_own);
    chk("bus_err",   bus_err,   dn && m_ill);
    chk("cpu_rdata", cpu_rdata, m_crd);
    chk("dma_rdata", dma_rdata, m_drd);
    if (acc) begin
      chk("bus_addr",  bus_addr,  m_addr);
      chk("bus_wdata", bus_wdata, m_wdata);
    end
  end

  typedef struct {
    bit dma; bit rd; bit wr;
    logic [31:0] addr, wdata, rdin;
    int lat, nram, nio, nwe;
    bit err;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt[8];

  task automatic run_one(input vec_t v);
    int lat, nram, nio, nwe;
    bit err, got;
    logic [31:0] rd;
    lat = 0; nram = 0; nio = 0; nwe = 0; err = 0; got = 0; rd = 0;
    @(negedge clk);
    ram_rdata = (v.addr[31:28] >= 4'hE) ? ~v.rdin : v.rdin;
    io_rdata  = (v.addr[31:28] >= 4'hE) ? v.rdin : ~v.rdin;
    if (v.dma) begin
      dma_req = 1; dma_wr = v.wr; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      nram += ram_sel; nio += io_sel; nwe += bus_we;
      if (bus_err) err = 1;
      if (v.dma ? dma_ready : cpu_ready) begin
        got = 1; rd = v.dma ? dma_rdata : cpu_rdata;
      end
    end
    @(negedge clk);
    cpu_req = 0; dma_req = 0;
    if (!got) chk("ready_timeout", 0, 1);
    else begin
      chk("latency", lat, v.lat);
      chk("ram_sel_cycles", nram, v.nram);
      chk("io_sel_cycles", nio, v.nio);
      chk("we_cycles", nwe, v.nwe);
      chk("bus_err_pulse", err, v.err);
      chk("rdata", rd, v.rdata);
    end
  endtask

  // Both requesters held; record the owner of the first three grants.
  task automatic contention(input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2);
    logic [1:0] seen[$];
    logic [1:0] prev;
    int n;
    prev = 0; n = 0;
    @(negedge clk);
    cpu_req = 1; cpu_rd = 1; cpu_wr = 0; cpu_addr = 32'h40;
    dma_req = 1; dma_wr = 0; dma_addr = 32'h80;
    while (seen.size() < 3 && n < 60) begin
      @(posedge clk); #1; n++;
      if (grant != 0 && prev == 0) seen.push_back(grant);
      prev = grant;
    end
    n = 0;
    while (!(cpu_ready || dma_ready) && n < 20) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    cpu_req = 0; dma_req = 0;
    if (seen.size() < 3) chk("contention_timeout", seen.size(), 3);
    else begin
      chk("grant_1st", seen[0], e0);
      chk("grant_2nd", seen[1], e1);
      chk("grant_3rd", seen[2], e2);
    end
  endtask

  task automatic new_cpu();
    int r;
    r = $urandom_range(0, 7);
    cpu_req = 1;
    if (r == 0)      begin cpu_rd = 1; cpu_wr = 1; end
    else if (r == 1) begin cpu_rd = 0; cpu_wr = 0; end
    else begin cpu_rd = r[0]; cpu_wr = !r[0]; end
    cpu_addr = {4'($urandom_range(0, 15)), 28'($urandom)};
    cpu_wdata = $urandom;
  endtask

  task automatic new_dma();
    dma_req = 1; dma_wr = 1'($urandom);
    dma_addr = {4'($urandom_range(0, 15)), 28'($urandom)};
    dma_wdata = $urandom;
  endtask

  initial begin
    //        dma rd wr addr           wdata          rdin           lat ram io we err rdata
    vt[0] = '{0, 1, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 3, 2, 0, 0, 0, 32'h1234_5678};
    vt[1] = '{0, 0, 1, 32'hE000_0000, 32'hA5A5_A5A5, 32'h1111_1111, 5, 0, 4, 4, 0, 32'h1234_5678};
    vt[2] = '{0, 1, 0, 32'hDFFF_FFFC, 32'h0,         32'hCAFE_F00D, 3, 2, 0, 0, 0, 32'hCAFE_F00D};
    vt[3] = '{0, 1, 0, 32'hE000_0000, 32'h0,         32'h0BAD_BEEF, 5, 0, 4, 0, 0, 32'h0BAD_BEEF};
    vt[4] = '{0, 1, 1, 32'h0000_0010, 32'h7,         32'h2222_2222, 3, 0, 0, 0, 1, 32'h0BAD_BEEF};
    vt[5] = '{0, 0, 0, 32'hF000_0000, 32'h7,         32'h3333_3333, 5, 0, 0, 0, 1, 32'h0BAD_BEEF};
    vt[6] = '{1, 0, 1, 32'h0000_0100, 32'h5,         32'h4444_4444, 3, 2, 0, 2, 0, 32'h0};
    vt[7] = '{1, 1, 0, 32'hFFFF_FFF0, 32'h0,         32'h55AA_1234, 5, 0, 4, 0, 0, 32'h55AA_1234};

    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_strobes", {bus_we, ram_sel, io_sel, cpu_ready, dma_ready, bus_err}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_rdata", cpu_rdata | dma_rdata, 0);
    reset = 0;
    check_en = 1;

`ifdef MIO_CPU_PRIORITY_EN
    contention(2'b01, 2'b01, 2'b01);
`else
    contention(2'b01, 2'b10, 2'b01);
`endif
    for (int i = 0; i < 8; i++) run_one(vt[i]);

    // Reset in the 2nd ACCESS cycle of a DMA write, after a CPU win.
    run_one(vt[0]);
    @(negedge clk);
    dma_req = 1; dma_wr = 1; dma_addr = 32'hE000_0040; dma_wdata = 32'hDEAD_0001;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_we", bus_we, 1);
    reset = 1; #1;
    chk("mid_rst_we", bus_we, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_dma_ready", dma_ready, 0);
    chk("mid_rst_io_sel", io_sel, 0);
    dma_req = 0;
    @(negedge clk);
    reset = 0;
`ifdef MIO_CPU_PRIORITY_EN
    contention(2'b01, 2'b01, 2'b01);
`else
    contention(2'b01, 2'b10, 2'b01);
`endif

    repeat (3000) begin
      @(negedge clk);
      ram_rdata = $urandom; io_rdata = $urandom;
      if (cpu_req) begin
        if (cpu_ready) begin if ($urandom_range(0, 1) == 1) new_cpu(); else cpu_req = 0; end
      end else if ($urandom_range(0, 2) == 0) new_cpu();
      if (dma_req) begin
        if (dma_ready) begin if ($urandom_range(0, 1) == 1) new_dma(); else dma_req = 0; end
      end else if ($urandom_range(0, 2) == 0) new_dma();
    end
    @(negedge clk);
    cpu_req = 0; dma_req = 0;
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Shares the single memory/IO bus between the multicycle CPU controller and a DMA/loader port.
- Arbitrates requests and applies per-region wait states.
- Returns a one-cycle ready pulse (drives the CPU's MIO_ready) together with captured read data.
- Sits between the CPU datapath/controller, RAM and the peripheral (IO) space.

Parameters:
- RAM_WAIT, 1, extra ACCESS cycles for RAM-region transfers (0..15)
- IO_WAIT, 3, extra ACCESS cycles for IO-region transfers (0..15)
- IO_REGION, 4'hE, addr[31:28] >= IO_REGION selects IO space; below selects RAM

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU bus request (CPU_MIO)
- cpu_rd  in  1  CPU read (MemRead)
- cpu_wr  in  1  CPU write (MemWrite)
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  read data to CPU
- cpu_ready  out  1  one-cycle completion pulse to CPU (MIO_ready)
- dma_req  in  1  DMA request
- dma_wr  in  1  DMA write (0 = read)
- dma_addr  in  32  DMA address
- dma_wdata  in  32  DMA write data
- dma_rdata  out  32  read data to DMA
- dma_ready  out  1  one-cycle completion pulse to DMA
- bus_addr  out  32  shared bus address
- bus_wdata  out  32  shared bus write data
- bus_we  out  1  write strobe
- ram_sel  out  1  RAM region select
- io_sel  out  1  IO region select
- ram_rdata  in  32  RAM read data
- io_rdata  in  32  IO read data
- grant  out  2  {dma,cpu} one-hot owner, 00 = idle
- bus_err  out  1  one-cycle pulse on illegal CPU request

Behaviour:
- Reset values:
  - All outputs 0.
  - state = IDLE, wait counter = 0.
  - last_grant = DMA, so the CPU wins the first contention.
  - Reset mid-transfer aborts it: no ready pulse, strobes drop immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples requests each edge.
  - Only one requester active -> grant it.
  - Both active -> grant the requester not equal to last_grant (round-robin).
  - At grant, latch the owner's addr, wdata, direction and region into bus registers; load the counter with RAM_WAIT or IO_WAIT (4-bit); go to ACCESS.
- ACCESS:
  - Lasts WAIT+1 cycles.
  - bus_addr, bus_wdata, ram_sel/io_sel and grant are held stable.
  - bus_we is high during every ACCESS cycle of a write.
  - Counter decrements; in the cycle it reads 0, capture read data (ram_rdata or io_rdata by region), update last_grant, go to DONE.
- DONE:
  - Owner's ready is high for exactly this cycle.
  - Owner's rdata is updated here and held until its next read completes; writes leave rdata unchanged.
  - bus_we, ram_sel, io_sel and grant are 0.
  - Next state is IDLE.
- Latency: request sampled at edge 0 -> ready high in cycle WAIT+2. With RAM_WAIT=1, the CPU sees MIO_ready 3 cycles after asserting CPU_MIO.
- Requester protocol:
  - Requester holds req and operands until it sees ready.
  - A req still high in the cycle after DONE is a new request.
  - Requests arriving during ACCESS/DONE wait; they are never dropped.
- Illegal CPU request (cpu_req with cpu_rd == cpu_wr):
  - Granted normally, but ram_sel, io_sel and bus_we stay 0.
  - cpu_ready and bus_err pulse together in DONE.
  - cpu_rdata is unchanged.
- Region decode uses only addr[31:28]. Address 32'hE000_0000 is IO; 32'hDFFF_FFFC is RAM.

Optional Feature:
- Macro: MIO_CPU_PRIORITY_EN.
- Defined: fixed priority; the CPU always wins contention in IDLE. last_grant is still maintained but ignored.
- Undefined: round-robin as above.

Test Plan:
- CPU RAM read only: cpu_req=1, cpu_rd=1, addr=0x0000_0010, ram_rdata=0x1234_5678, RAM_WAIT=1 -> ram_sel high 2 cycles; cpu_ready high in cycle 3; cpu_rdata=0x1234_5678.
- CPU IO write: addr=0xE000_0000, wdata=0xA5A5_A5A5, IO_WAIT=3 -> io_sel and bus_we high 4 cycles; cpu_ready in cycle 5; cpu_rdata unchanged.
- Contention: both requests in the same cycle after reset -> CPU granted first; DMA granted in the IDLE following CPU DONE; with both held, grants alternate CPU, DMA, CPU.
- Illegal request: cpu_rd=cpu_wr=1 -> no ram_sel/io_sel/bus_we; bus_err and cpu_ready pulse together.
- Reset mid-operation: reset in 2nd ACCESS cycle of a DMA write -> bus_we, grant and dma_ready go 0 asynchronously; after release, CPU wins the next contention.
- MIO_CPU_PRIORITY_EN defined, both requesters held continuously -> CPU granted every transaction; DMA never granted.
